// File: rtl/if_seg_queue.sv
// IF-stage fetch buffer: DEPTH-entry FIFO carrying fetch PC plus BHT metadata,
// valid/ready on both sides, single-cycle flush on redirect.
module if_seg_queue #(
  parameter int DEPTH     = 4,
  parameter int PC_W      = 32,
  parameter int BHT_IDX_W = 3,
  parameter int CNT_W     = 2,
  parameter int CNT_IDX_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [CNT_W-1:0]     in_flags,
  input  logic [BHT_IDX_W-1:0] in_index,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [CNT_W-1:0]     out_flags,
  output logic [BHT_IDX_W-1:0] out_index,
  output logic                 out_pred_taken,
  output logic [CNT_IDX_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_IDX_W-1:0] FULL_COUNT = CNT_IDX_W'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic [CNT_W-1:0]     flags;
    logic [BHT_IDX_W-1:0] index;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head is read straight from storage; an empty buffer presents the IF clear value.
  assign head           = mem[rd_ptr];
  assign out_pc         = out_valid ? head.pc    : '0;
  assign out_flags      = out_valid ? head.flags : '0;
  assign out_index      = out_valid ? head.index : '0;
  assign out_pred_taken = out_valid & head.flags[CNT_W-1];

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset too so the head never exposes X after reset;
      // flush deliberately leaves it alone since out_* are masked by count.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: in_pc, flags: in_flags, index: in_index};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_IDX_W'(1);
        2'b01:   count <= count - CNT_IDX_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_seg_queue.sv
// Scoreboard bench for if_seg_queue: stimulus queues expected head entries,
// a negedge monitor compares every accepted pop against them.
module tb_if_seg_queue;

  localparam int DEPTH     = 4;
  localparam int PC_W      = 32;
  localparam int BHT_IDX_W = 3;
  localparam int CNT_W     = 2;
  localparam int CNT_IDX_W = $clog2(DEPTH + 1);

  typedef struct {
    logic [PC_W-1:0]      pc;
    logic [CNT_W-1:0]     flags;
    logic [BHT_IDX_W-1:0] index;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [PC_W-1:0]      in_pc = '0;
  logic [CNT_W-1:0]     in_flags = '0;
  logic [BHT_IDX_W-1:0] in_index = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [PC_W-1:0]      out_pc;
  logic [CNT_W-1:0]     out_flags;
  logic [BHT_IDX_W-1:0] out_index;
  logic                 out_pred_taken;
  logic [CNT_IDX_W-1:0] count;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  if_seg_queue #(
    .DEPTH(DEPTH), .PC_W(PC_W), .BHT_IDX_W(BHT_IDX_W), .CNT_W(CNT_W), .CNT_IDX_W(CNT_IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_flags(in_flags), .in_index(in_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_flags(out_flags),
    .out_index(out_index), .out_pred_taken(out_pred_taken), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one entry; queue it as expected only when the bench knows it will be accepted.
  task automatic offer(input logic [PC_W-1:0] pc, input logic [CNT_W-1:0] fl,
                       input logic [BHT_IDX_W-1:0] idx, input bit accepted);
    exp_t e;
    in_valid = 1'b1;
    in_pc    = pc;
    in_flags = fl;
    in_index = idx;
    if (accepted) begin
      e.pc = pc; e.flags = fl; e.index = idx;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_pc    = '0;
    in_flags = '0;
    in_index = '0;
  endtask

  // Monitor: a transfer happens at the next edge when out_valid & out_ready and no flush.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !flush && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output_pc", out_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", out_pc, e.pc);
          check("pop_flags", 32'(out_flags), 32'(e.flags));
          check("pop_index", 32'(out_index), 32'(e.index));
          check("pop_pred_taken", 32'(out_pred_taken), 32'(e.flags[CNT_W-1]));
        end
      end
    end
  end

  initial begin
    // Power-up reset.
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_count", 32'(count), 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_flags", 32'(out_flags), 0);
    check("rst_out_index", 32'(out_index), 0);
    check("rst_pred_taken", 32'(out_pred_taken), 0);
    rst = 1'b0;
    step();

    // Single push and its one-cycle latency.
    offer(32'h100, 2'b11, 3'd5, 1'b1);
    check("t2_no_bypass_valid", 32'(out_valid), 0);
    step();
    idle_in();
    check("t2_out_valid", 32'(out_valid), 1);
    check("t2_out_pc", out_pc, 32'h100);
    check("t2_out_flags", 32'(out_flags), 3);
    check("t2_out_index", 32'(out_index), 5);
    check("t2_pred_taken", 32'(out_pred_taken), 1);
    check("t2_count", 32'(count), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t2_drained_count", 32'(count), 0);

    // Fill to DEPTH, overflow push ignored, then drain in order.
    for (int k = 0; k < 4; k++) begin
      offer(32'(4 * k), 2'(k), 3'(k + 1), 1'b1);
      step();
    end
    check("t3_full_count", 32'(count), 4);
    check("t3_full_in_ready", 32'(in_ready), 0);
    offer(32'h10, 2'b11, 3'd7, 1'b0);
    step();
    idle_in();
    check("t3_ignored_count", 32'(count), 4);
    check("t3_head_kept", out_pc, 32'h0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    out_ready = 1'b0;
    check("t3_empty_count", 32'(count), 0);
    check("t3_empty_valid", 32'(out_valid), 0);
    check("t3_empty_pc", out_pc, 0);
    check("t3_empty_in_ready", 32'(in_ready), 1);

    // Streaming at count = 1 across several pointer wraps.
    offer(32'h200, 2'b00, 3'd0, 1'b1);
    step();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      offer(32'h200 + 32'(4 * k), 2'(k), 3'(k), 1'b1);
      step();
      check("t4_stream_count", 32'(count), 1);
      check("t4_stream_head", out_pc, 32'h200 + 32'(4 * k));
    end
    idle_in();
    step();
    out_ready = 1'b0;
    check("t4_final_count", 32'(count), 0);
    check("t4_queue_drained", 32'(exp_q.size()), 0);

    // Flush colliding with push and pop.
    for (int k = 0; k < 3; k++) begin
      offer(32'h400 + 32'(4 * k), 2'b10, 3'(k), 1'b1);
      step();
    end
    check("t5_pre_count", 32'(count), 3);
    flush = 1'b1;
    out_ready = 1'b1;
    offer(32'hDEAD, 2'b11, 3'd6, 1'b0);
    step();
    flush = 1'b0;
    idle_in();
    exp_q.delete();
    check("t5_count", 32'(count), 0);
    check("t5_out_valid", 32'(out_valid), 0);
    check("t5_in_ready", 32'(in_ready), 1);
    check("t5_out_pc", out_pc, 0);
    step();
    step();
    check("t5_stays_empty", 32'(count), 0);
    // Pointers restart cleanly after flush.
    offer(32'h300, 2'b01, 3'd2, 1'b1);
    step();
    idle_in();
    check("t5_post_pc", out_pc, 32'h300);
    step();
    out_ready = 1'b0;
    check("t5_post_count", 32'(count), 0);

    // Prediction bit follows the head counter MSB.
    offer(32'h500, 2'b01, 3'd1, 1'b1);
    step();
    check("t6_first_pred", 32'(out_pred_taken), 0);
    offer(32'h504, 2'b10, 3'd2, 1'b1);
    step();
    idle_in();
    check("t6_head_pred", 32'(out_pred_taken), 0);
    out_ready = 1'b1;
    step();
    check("t6_second_pred", 32'(out_pred_taken), 1);
    check("t6_second_pc", out_pc, 32'h504);
    step();
    out_ready = 1'b0;
    check("t6_empty_pred", 32'(out_pred_taken), 0);

    // Asynchronous reset mid-cycle with entries held.
    offer(32'h600, 2'b11, 3'd3, 1'b0);
    step();
    offer(32'h604, 2'b11, 3'd4, 1'b0);
    step();
    idle_in();
    check("t1_pre_count", 32'(count), 2);
    #2;
    rst = 1'b1;
    #1;
    check("t1_async_valid", 32'(out_valid), 0);
    check("t1_async_count", 32'(count), 0);
    check("t1_async_in_ready", 32'(in_ready), 1);
    check("t1_async_pc", out_pc, 0);
    check("t1_async_pred", 32'(out_pred_taken), 0);
    step();
    rst = 1'b0;
    step();
    check("t1_after_count", 32'(count), 0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
